// File: rtl/nn_pkg.sv
// Shared types and constants for the MNIST inference datapath.
// Sizes the output layer and the classifier FSM.
package nn_pkg;

  localparam int NUM_ROWS      = 10;
  localparam int RESULT_WIDTH  = 16;
  localparam int ROW_IDX_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/sync_timeout_counter.sv
// Watchdog counter with synchronous clear and enable.
// expire is high while enabled on the terminal count.
module sync_timeout_counter #(
  parameter int TERMINAL = 2048
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(TERMINAL + 1);
  localparam logic [W-1:0] LAST = W'(TERMINAL - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != LAST) begin
      count <= count + 1'b1;
    end
  end

  assign expire = enable && (count == LAST);

endmodule

// File: rtl/digit_classifier.sv
// Sequences the multiplier over every output row and
// reports the argmax row as the classified digit.
module digit_classifier
  import nn_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_classify,
  input  logic                    done_row,
  input  logic [RESULT_WIDTH-1:0] row_result,
  output logic                    begin_mult,
  output logic [3:0]              row_index,
  output logic                    busy,
  output logic [3:0]              digit,
  output logic                    digit_valid,
  output logic                    error
);

  localparam logic [ROW_IDX_WIDTH-1:0] LAST_ROW =
    ROW_IDX_WIDTH'(NUM_ROWS - 1);
  localparam logic [RESULT_WIDTH-1:0] MIN_RESULT =
    {1'b1, {(RESULT_WIDTH-1){1'b0}}};

  state_t                  state;
  logic [RESULT_WIDTH-1:0] max_q;
  logic [RESULT_WIDTH-1:0] result_q;
  logic [3:0]              best_q;
  logic [3:0]              best_next;
  logic                    waiting;
  logic                    expire;
  logic                    gt;

  // The count reads 0 in ISSUE and advances through WAIT,
  // so the stall is flagged TIMEOUT_CYCLES after begin_mult.
  assign waiting = (state == ISSUE) || (state == WAIT);

  sync_timeout_counter #(
    .TERMINAL(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (!waiting),
    .enable(waiting),
    .expire(expire)
  );

  assign gt = $signed(result_q) > $signed(max_q);
  assign best_next = gt ? row_index : best_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      max_q       <= MIN_RESULT;
      result_q    <= '0;
      best_q      <= '0;
      begin_mult  <= 1'b0;
      row_index   <= '0;
      busy        <= 1'b0;
      digit       <= '0;
      digit_valid <= 1'b0;
      error       <= 1'b0;
    end else begin
      begin_mult  <= 1'b0;
      digit_valid <= 1'b0;
      unique case (state)
        IDLE, DONE, ERROR: begin
          if (start_classify) begin
            state      <= ISSUE;
            row_index  <= '0;
            max_q      <= MIN_RESULT;
            best_q     <= '0;
            error      <= 1'b0;
            busy       <= 1'b1;
            begin_mult <= 1'b1;
          end else if (state == DONE) begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (done_row) begin
            result_q <= row_result;
            state    <= CAPTURE;
          end else if (expire) begin
            state <= ERROR;
            busy  <= 1'b0;
            error <= 1'b1;
          end
        end
        CAPTURE: begin
          // Strict compare: ties keep the lower row.
          if (gt) begin
            max_q  <= result_q;
            best_q <= row_index;
          end
          if (row_index == LAST_ROW) begin
            state       <= DONE;
            busy        <= 1'b0;
            digit       <= best_next;
            digit_valid <= 1'b1;
          end else begin
            row_index  <= row_index + 1'b1;
            state      <= ISSUE;
            begin_mult <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_classifier.sv
// Directed bench for digit_classifier with a simple
// multiplier responder and table-driven result vectors.
module tb_digit_classifier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_classify;
  logic        done_row;
  logic [15:0] row_result;
  logic        begin_mult;
  logic [3:0]  row_index;
  logic        busy;
  logic [3:0]  digit;
  logic        digit_valid;
  logic        error;

  always #5 clk = ~clk;

  digit_classifier #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_classify(start_classify),
    .done_row      (done_row),
    .row_result    (row_result),
    .begin_mult    (begin_mult),
    .row_index     (row_index),
    .busy          (busy),
    .digit         (digit),
    .digit_valid   (digit_valid),
    .error         (error)
  );

  typedef struct {
    logic [15:0] res [10];
    int          exp;
  } vec_t;

  vec_t        vecs [6];
  logic [15:0] cur_res [10];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Drives start and answers each begin_mult with done_row
  // in the first WAIT cycle, except for the stalled row.
  task automatic run_class(
    input  bit hold, input int target, input int stall,
    output int nbeg, output int nval, output int dig,
    output int lat, output int err_lat);
    int  first_c, issue_c, prow;
    bit  pend, fin;
    nbeg = 0; nval = 0; dig = -1; lat = -1;
    err_lat = -1; first_c = -1; issue_c = -1;
    prow = 0; pend = 0; fin = 0;
    start_classify = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      done_row = 1'b0;
      if (pend) begin
        done_row   = 1'b1;
        row_result = cur_res[prow];
        pend       = 1'b0;
      end
      if (begin_mult) begin
        nbeg++;
        prow    = int'(row_index);
        pend    = (prow != stall);
        issue_c = c;
        if (first_c < 0) first_c = c;
      end
      if (digit_valid) begin
        nval++;
        dig = int'(digit);
        lat = c - first_c;
      end
      if (error) err_lat = c - issue_c;
      if (nval == target || error) begin
        fin = 1'b1;
        break;
      end
      start_classify = hold;
    end
    start_classify = 1'b0;
    done_row       = 1'b0;
    if (!fin) chk("run_budget", 0, 1);
  endtask

  int nbeg, nval, dig, lat, err_lat;
  bit found;

  initial begin
    for (int r = 0; r < 10; r++) begin
      vecs[0].res[r] = 16'(100 + r);
      vecs[1].res[r] = 16'h0000;
      vecs[2].res[r] = 16'(-100 + r);
      vecs[3].res[r] = 16'h8000;
      vecs[4].res[r] = 16'(-5);
      vecs[5].res[r] = 16'(r);
    end
    vecs[0].res[7] = 16'd5000;  vecs[0].exp = 7;
    vecs[1].res[2] = 16'h7FFF;
    vecs[1].res[5] = 16'h7FFF;  vecs[1].exp = 2;
    vecs[2].exp = 9;
    vecs[3].exp = 0;
    vecs[4].res[0] = 16'd1;     vecs[4].exp = 0;
    vecs[5].res[0] = 16'h7FFE;
    vecs[5].res[9] = 16'h7FFF;  vecs[5].exp = 9;

    reset = 1'b1;
    start_classify = 1'b0;
    done_row = 1'b0;
    row_result = '0;
    repeat (3) @(negedge clk);
    chk("rst_begin", int'(begin_mult), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_row", int'(row_index), 0);
    chk("rst_digit", int'(digit), 0);
    chk("rst_valid", int'(digit_valid), 0);
    chk("rst_error", int'(error), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      cur_res = vecs[i].res;
      run_class(1'b0, 1, -1, nbeg, nval, dig, lat, err_lat);
      chk($sformatf("v%0d_digit", i), dig, vecs[i].exp);
      chk($sformatf("v%0d_begins", i), nbeg, 10);
      chk($sformatf("v%0d_valids", i), nval, 1);
      chk($sformatf("v%0d_latency", i), lat, 30);
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), int'(digit_valid), 0);
      chk($sformatf("v%0d_hold", i), int'(digit),
          vecs[i].exp);
      chk($sformatf("v%0d_idle", i), int'(busy), 0);
      chk($sformatf("v%0d_nobeg", i), int'(begin_mult), 0);
    end

    // Stall on row 2 with a 16-cycle watchdog.
    cur_res = vecs[0].res;
    run_class(1'b0, 1, 2, nbeg, nval, dig, lat, err_lat);
    chk("stall_begins", nbeg, 3);
    chk("stall_latency", err_lat, 16);
    chk("stall_row", int'(row_index), 2);
    chk("stall_busy", int'(busy), 0);
    @(negedge clk);
    chk("stall_held", int'(error), 1);
    chk("stall_frozen", int'(row_index), 2);
    run_class(1'b0, 1, -1, nbeg, nval, dig, lat, err_lat);
    chk("recover_digit", dig, 7);
    chk("recover_error", int'(error), 0);
    chk("recover_begins", nbeg, 10);

    // Reset while waiting on row 4.
    cur_res = vecs[2].res;
    start_classify = 1'b1;
    found = 1'b0;
    begin
      bit pend;
      int prow;
      pend = 1'b0;
      prow = 0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        start_classify = 1'b0;
        done_row = 1'b0;
        if (pend) begin
          done_row   = 1'b1;
          row_result = cur_res[prow];
          pend       = 1'b0;
        end
        if (begin_mult) begin
          if (row_index == 4'd4) begin
            found = 1'b1;
            break;
          end
          prow = int'(row_index);
          pend = 1'b1;
        end
      end
    end
    chk("rst4_found", int'(found), 1);
    @(negedge clk);
    chk("rst4_in_wait", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst4_begin", int'(begin_mult), 0);
    chk("rst4_busy", int'(busy), 0);
    chk("rst4_row", int'(row_index), 0);
    chk("rst4_digit", int'(digit), 0);
    chk("rst4_valid", int'(digit_valid), 0);
    chk("rst4_error", int'(error), 0);
    done_row = 1'b1;
    row_result = 16'h7FFF;
    @(negedge clk);
    done_row = 1'b0;
    chk("rst4_nobeg", int'(begin_mult), 0);
    @(negedge clk);
    chk("spur_busy", int'(busy), 0);
    chk("spur_valid", int'(digit_valid), 0);
    cur_res = vecs[0].res;
    run_class(1'b0, 1, -1, nbeg, nval, dig, lat, err_lat);
    chk("fresh_digit", dig, 7);

    // Spurious done_row in IDLE, then start held high.
    @(negedge clk);
    done_row = 1'b1;
    row_result = 16'h7FFF;
    @(negedge clk);
    done_row = 1'b0;
    chk("idle_spur_begin", int'(begin_mult), 0);
    chk("idle_spur_busy", int'(busy), 0);
    chk("idle_spur_digit", int'(digit), 7);
    cur_res = vecs[1].res;
    run_class(1'b1, 2, -1, nbeg, nval, dig, lat, err_lat);
    chk("b2b_begins", nbeg, 20);
    chk("b2b_valids", nval, 2);
    chk("b2b_digit", dig, 2);
    @(negedge clk);
    chk("b2b_idle", int'(busy), 0);
    chk("b2b_nobeg", int'(begin_mult), 0);
    @(negedge clk);
    chk("b2b_stay", int'(begin_mult), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
